ssd_capture: RTL

//  Receive end of the multiplexed 8-digit seven-segment bus: samples an external seg/dig pair (active-low).

---
 rtl/ssd_pkg.sv | 26 ++
 rtl/ssd_capture_if.sv | 7 +
 rtl/ssd_seg_decode.sv | 13 +
 rtl/ssd_capture.sv | 97 +++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: active-low seven-segment pattern constants and decode result type.
package ssd_pkg;
  localparam int N_DIG_DEF = 8;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  typedef struct packed {
    logic       known;
    logic [3:0] code;
  } dec_t;
endpackage

// File: rtl/ssd_capture_if.sv
// ssd_capture_if: multiplexed seven-segment bus (active-low segments and anodes).
interface ssd_capture_if #(parameter int N_DIG = 8) ();
  logic [7:0]       seg_in;
  logic [N_DIG-1:0] dig_in;
  modport master (output seg_in, dig_in);
  modport slave  (input  seg_in, dig_in);
endinterface

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode: active-low gfedcba pattern to {known, hex code}.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] pat,
  output dec_t       res
);
  always_comb begin
    res = '0;
    for (int i = 0; i < 16; i++)
      if (pat == SEG_LUT[i]) res = '{known: 1'b1, code: 4'(i)};
  end
endmodule

// File: rtl/ssd_capture.sv
// ssd_capture: samples a multiplexed seven-segment bus, filters each digit for stability and stores decoded codes.
// Optional SSD_CAPTURE_DP_EN captures the decimal point per slot.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int N_DIG      = N_DIG_DEF,
  parameter int STABLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  ssd_capture_if.slave       bus,
  output logic [4*N_DIG-1:0] digit_code,
  output logic [N_DIG-1:0]   digit_valid,
  output logic [N_DIG-1:0]   dp_out,
  output logic               frame_done,
  output logic               err
);
  localparam int W  = 8 + N_DIG;
  localparam int CW = $clog2(STABLE_CYC + 1);
  logic [W-1:0] sync1_q, sync2_q, s_q, prev_q;
  logic [W-2:0] acc_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept_q, accept_d, err_q, err_d, frame_q, frame_d;
  logic [4*N_DIG-1:0] code_q, code_d;
  logic [N_DIG-1:0] valid_q, valid_d, seen_q, seen_d, dig;
  logic blank, single;
  dec_t dec;
  ssd_seg_decode u_dec (.pat(acc_q[W-2:N_DIG]), .res(dec));
  assign dig    = acc_q[N_DIG-1:0];
  assign blank  = &dig;
  assign single = $onehot(~dig);
  always_comb begin
    cnt_d    = (s_q == prev_q) ? ((cnt_q == CW'(STABLE_CYC)) ? cnt_q : cnt_q + 1'b1) : '0;
    accept_d = (cnt_q == CW'(STABLE_CYC - 1)) && (cnt_d == CW'(STABLE_CYC));
    err_d    = accept_q && !blank && !(single && dec.known);
    code_d   = code_q;
    valid_d  = valid_q;
    // a completing frame clears the mask before this cycle's accept is added
    seen_d   = frame_q ? '0 : seen_q;
    for (int i = 0; i < N_DIG; i++)
      if (accept_q && single && !dig[i]) begin
        code_d[4*i +: 4] = dec.known ? dec.code : 4'h0;
        valid_d[i]       = dec.known;
        seen_d[i]        = 1'b1;
      end
    frame_d  = &seen_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      s_q      <= '1;
      prev_q   <= '1;
      acc_q    <= '1;
      cnt_q    <= '0;
      accept_q <= 1'b0;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
      code_q   <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
    end else begin
      sync1_q  <= {bus.seg_in, bus.dig_in};
      sync2_q  <= sync1_q;
      s_q      <= sync2_q;
      prev_q   <= s_q;
      acc_q    <= s_q[W-2:0];
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
    end
  end
`ifdef SSD_CAPTURE_DP_EN
  logic acc_dp_q;
  logic [N_DIG-1:0] dp_q, dp_d;
  always_comb begin
    dp_d = dp_q;
    for (int i = 0; i < N_DIG; i++)
      if (accept_q && single && dec.known && !dig[i]) dp_d[i] = ~acc_dp_q;
  end
  always_ff @(posedge clk) begin
    acc_dp_q <= !rst_n ? 1'b1 : s_q[W-1];
    dp_q     <= !rst_n ? '0 : dp_d;
  end
  assign dp_out = dp_q;
`else
  assign dp_out = '0;
`endif
  assign digit_code  = code_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign err         = err_q;
endmodule
